// File: rtl/alu_result_stage.sv
// Registered result stage behind the bitwise units: selects a unit result by opcode,
// attaches zero/parity/negative flags and queues it in a 2-entry FIFO with a delivered count.
module alu_result_stage #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_and,
    input  logic [WIDTH-1:0] in_or,
    input  logic [WIDTH-1:0] in_xor,
    input  logic [WIDTH-1:0] in_not,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_zero,
    output logic             out_par,
    output logic             out_neg,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] res_count
);

    // Entry layout: {neg, par, zero, result}
    localparam int unsigned ENTRY_W = WIDTH + 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t               state;
    occ_t               state_nxt;
    logic [ENTRY_W-1:0] mem [2];
    logic               wr_ptr;
    logic               rd_ptr;
    logic               rd_nxt;
    logic               push;
    logic               pop;
    logic [WIDTH-1:0]   sel_res;
    logic [ENTRY_W-1:0] entry_new;
    logic [ENTRY_W-1:0] head_nxt;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Unit select and flag generation ahead of storage
    always_comb begin
        sel_res = in_and;
        case (in_op)
            2'b00:   sel_res = in_and;
            2'b01:   sel_res = in_or;
            2'b10:   sel_res = in_xor;
            default: sel_res = in_not;
        endcase
        entry_new = {sel_res[WIDTH-1], ^sel_res, (sel_res == '0), sel_res};
    end

    // Occupancy next-state and the entry that becomes head after this edge
    always_comb begin
        state_nxt = state;
        rd_nxt    = rd_ptr ^ pop;
        head_nxt  = mem[rd_nxt];
        case (state)
            EMPTY: begin
                if (push) state_nxt = ONE;
            end
            ONE: begin
                if (push && !pop)      state_nxt = FULL;
                else if (pop && !push) state_nxt = EMPTY;
            end
            FULL: begin
                if (pop) state_nxt = ONE;
            end
            default: state_nxt = EMPTY;
        endcase
        // A write landing in the next head slot must be forwarded into the output register
        if (push && (wr_ptr == rd_nxt)) head_nxt = entry_new;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr ^ push;
            rd_ptr    <= rd_nxt;
            in_ready  <= (state_nxt != FULL);
            out_valid <= (state_nxt != EMPTY);
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= entry_new;
    end

    // Output registers only move when a valid head exists, so they hold while idle or stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_res  <= '0;
            out_zero <= 1'b0;
            out_par  <= 1'b0;
            out_neg  <= 1'b0;
        end else if (state_nxt != EMPTY) begin
            out_res  <= head_nxt[WIDTH-1:0];
            out_zero <= head_nxt[WIDTH];
            out_par  <= head_nxt[WIDTH+1];
            out_neg  <= head_nxt[WIDTH+2];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_count <= '0;
        end else if (cnt_clr) begin
            res_count <= '0;
        end else if (pop && (res_count != CNT_MAX)) begin
            res_count <= res_count + CNT_W'(1);
        end
    end

endmodule
